// File: rtl/fp16_mac_sched.sv
// fp16_mac_sched: round-robin scheduler feeding two requesters' dot-product jobs into one shared fp16 MAC.
// Optional build macro: FP16_SCHED_ZERO_SKIP_EN (pairs with a +/-0 operand are counted but not issued).
// Ports:
//   clk83, reset_n83          clock, synchronous active-low reset
//   req_valid83/req_len83     per-requester job request and length (LEN_W bits each)
//   req_grant83               one-cycle job accept pulse
//   op_valid83/op_ready83     per-requester operand pair handshake, op_a83/op_b83 packed 16 bits per requester
//   res_valid83/res83/res_ack83  result handshake towards the owning requester
//   mac_clr83/mac_start83     accumulator clear and operand issue pulses, mac_a83/mac_b83 operands
//   mac_done83/mac_ans83      MAC completion and running result
//   busy83, err_timeout83     not-idle status, sticky MAC timeout flag
module fp16_mac_sched #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk83,
  input  logic               reset_n83,
  input  logic [1:0]         req_valid83,
  input  logic [2*LEN_W-1:0] req_len83,
  output logic [1:0]         req_grant83,
  input  logic [1:0]         op_valid83,
  input  logic [31:0]        op_a83,
  input  logic [31:0]        op_b83,
  output logic [1:0]         op_ready83,
  output logic [1:0]         res_valid83,
  output logic [15:0]        res83,
  input  logic [1:0]         res_ack83,
  output logic               mac_clr83,
  output logic               mac_start83,
  output logic [15:0]        mac_a83,
  output logic [15:0]        mac_b83,
  input  logic               mac_done83,
  input  logic [15:0]        mac_ans83,
  output logic               busy83,
  output logic               err_timeout83
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0] state_q, state_d;
  logic g_q, g_d, last_q, last_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0] res_q, res_d, a_q, a_d, b_q, b_d, opa, opb;
  logic [1:0] grant_q, grant_d, ready_q, ready_d, valid_q, valid_d;
  logic clr_q, clr_d, start_q, start_d, busy_q, busy_d, err_q, err_d;
  logic pick, last_pair, skip;
  always_comb begin
    pick      = &req_valid83 ? ~last_q : req_valid83[1];
    opa       = g_q ? op_a83[31:16] : op_a83[15:0];
    opb       = g_q ? op_b83[31:16] : op_b83[15:0];
    cnt_inc   = cnt_q + 1'b1;
    last_pair = cnt_inc == len_q;
`ifdef FP16_SCHED_ZERO_SKIP_EN
    skip      = opa[14:0] == 15'd0 || opb[14:0] == 15'd0;
`else
    skip      = 1'b0;
`endif
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    grant_d = 2'b00;
    clr_d   = 1'b0;
    start_d = 1'b0;
    case (state_q)
      IDLE: if (|req_valid83) begin
        g_d     = pick;
        len_d   = pick ? req_len83[2*LEN_W-1:LEN_W] : req_len83[LEN_W-1:0];
        grant_d = pick ? 2'b10 : 2'b01;
        cnt_d   = '0;
        res_d   = 16'h0000;
        clr_d   = len_d != '0;
        state_d = len_d == '0 ? RESP : CLEAR;
      end
      CLEAR: begin
        cnt_d   = '0;
        res_d   = 16'h0000;
        state_d = ISSUE;
      end
      ISSUE: if (op_valid83[g_q]) begin
        if (skip) begin
          cnt_d   = cnt_inc;
          state_d = last_pair ? RESP : ISSUE;
        end else begin
          a_d     = opa;
          b_d     = opb;
          start_d = 1'b1;
          tmr_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: if (mac_done83) begin
        res_d   = mac_ans83;
        cnt_d   = cnt_inc;
        state_d = last_pair ? RESP : ISSUE;
      end else if (tmr_q == TW'(TIMEOUT - 1)) begin
        res_d   = 16'h7E00;
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        tmr_d   = tmr_q + 1'b1;
      end
      RESP: if (res_ack83[g_q]) begin
        last_d  = g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered, so they follow the state being entered.
    ready_d = state_d == ISSUE ? (g_d ? 2'b10 : 2'b01) : 2'b00;
    valid_d = state_d == RESP ? (g_d ? 2'b10 : 2'b01) : 2'b00;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk83) begin
    if (!reset_n83) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      res_q   <= 16'h0000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      grant_q <= 2'b00;
      ready_q <= 2'b00;
      valid_q <= 2'b00;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      clr_q   <= clr_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end
  assign req_grant83   = grant_q;
  assign op_ready83    = ready_q;
  assign res_valid83   = valid_q;
  assign res83         = res_q;
  assign mac_clr83     = clr_q;
  assign mac_start83   = start_q;
  assign mac_a83       = a_q;
  assign mac_b83       = b_q;
  assign busy83        = busy_q;
  assign err_timeout83 = err_q;
endmodule

// File: tb/tb_fp16_mac_sched.sv
// tb_fp16_mac_sched: directed self-checking bench for fp16_mac_sched with a two-cycle MAC model.
module tb_fp16_mac_sched;
  logic        clk83 = 1'b0;
  logic        reset_n83 = 1'b0;
  logic [1:0]  req_valid83 = 2'b00;
  logic [7:0]  req_len83 = 8'h00;
  logic [1:0]  req_grant83;
  logic [1:0]  op_valid83 = 2'b00;
  logic [31:0] op_a83 = 32'h0;
  logic [31:0] op_b83 = 32'h0;
  logic [1:0]  op_ready83;
  logic [1:0]  res_valid83;
  logic [15:0] res83;
  logic [1:0]  res_ack83 = 2'b00;
  logic        mac_clr83;
  logic        mac_start83;
  logic [15:0] mac_a83;
  logic [15:0] mac_b83;
  logic        mac_done83 = 1'b0;
  logic [15:0] mac_ans83 = 16'h0000;
  logic        busy83;
  logic        err_timeout83;
  int asserts = 0;
  int failures = 0;
  logic        mac_en = 1'b1;
  logic        force_done = 1'b0;
  int          done_base = 0;
  logic [15:0] ans_tab [4];
  int n_start = 0, n_clr = 0, n_clrbad = 0, n_done = 0, n_both = 0, cd = 0;
  int n_g [2];
  logic [3:0]  jl [2];
  logic [15:0] pa [4];
  logic [15:0] pb [4];
  logic [15:0] rres [2];
  int rcyc [2], gcyc [2], gorder [2], ng;
  int di;

  fp16_mac_sched dut (
    .clk83(clk83), .reset_n83(reset_n83),
    .req_valid83(req_valid83), .req_len83(req_len83), .req_grant83(req_grant83),
    .op_valid83(op_valid83), .op_a83(op_a83), .op_b83(op_b83), .op_ready83(op_ready83),
    .res_valid83(res_valid83), .res83(res83), .res_ack83(res_ack83),
    .mac_clr83(mac_clr83), .mac_start83(mac_start83), .mac_a83(mac_a83), .mac_b83(mac_b83),
    .mac_done83(mac_done83), .mac_ans83(mac_ans83),
    .busy83(busy83), .err_timeout83(err_timeout83)
  );

  always #5 clk83 = ~clk83;

  // MAC model and event counters, sampled mid-cycle: done follows a start by two cycles.
  initial begin
    n_g[0] = 0;
    n_g[1] = 0;
    forever begin
      @(negedge clk83);
      if (mac_start83) n_start++;
      if (mac_clr83) n_clr++;
      if (mac_clr83 && req_grant83 == 2'b00) n_clrbad++;
      if (req_grant83[0]) n_g[0]++;
      if (req_grant83[1]) n_g[1]++;
      if (op_ready83 == 2'b11) n_both++;
      mac_done83 = force_done || cd == 1;
      if (force_done) mac_ans83 = 16'h1234;
      if (cd == 1) begin
        di = n_done - done_base;
        mac_ans83 = ans_tab[di[1:0]];
        n_done++;
      end
      if (cd > 0) cd--;
      if (mac_start83 && mac_en) cd = 2;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk83);
    #1;
  endtask

  task automatic run(input logic [1:0] which, input int budget);
    int k [2];
    logic [1:0] fin, acc;
    k[0] = 0;
    k[1] = 0;
    fin = ~which;
    ng = 0;
    req_len83 = {jl[1], jl[0]};
    req_valid83 = which;
    for (int r = 0; r < 2; r++) begin
      op_valid83[r] = which[r] && jl[r] != 4'd0;
      op_a83[r*16 +: 16] = pa[0];
      op_b83[r*16 +: 16] = pb[0];
    end
    for (int c = 0; c < budget && fin != 2'b11; c++) begin
      acc = op_ready83 & op_valid83;
      tick();
      res_ack83 = 2'b00;
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) k[r]++;
        if (req_grant83[r]) begin
          req_valid83[r] = 1'b0;
          if (ng < 2) gorder[ng] = r;
          ng++;
          gcyc[r] = c;
        end
        op_valid83[r] = which[r] && !fin[r] && k[r] < int'(jl[r]);
        op_a83[r*16 +: 16] = pa[k[r][1:0]];
        op_b83[r*16 +: 16] = pb[k[r][1:0]];
        if (res_valid83[r] && !fin[r]) begin
          rres[r] = res83;
          rcyc[r] = c;
          res_ack83[r] = 1'b1;
          fin[r] = 1'b1;
          op_valid83[r] = 1'b0;
        end
      end
    end
    asserts++;
    if (fin != 2'b11) begin failures++; $display("FAIL run_done: finished %b want 11", fin); end
    tick();
    res_ack83 = 2'b00;
    req_valid83 = 2'b00;
    op_valid83 = 2'b00;
  endtask

  task automatic test_reset();
    reset_n83 = 1'b0;
    tick();
    tick();
    asserts++; if (busy83 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy83); end
    asserts++; if (req_grant83 !== 2'b00) begin failures++; $display("FAIL rst_grant: got %b want 00", req_grant83); end
    asserts++; if (op_ready83 !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b want 00", op_ready83); end
    asserts++; if (res_valid83 !== 2'b00) begin failures++; $display("FAIL rst_valid: got %b want 00", res_valid83); end
    asserts++; if ({mac_clr83, mac_start83, err_timeout83} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b want 000", {mac_clr83, mac_start83, err_timeout83}); end
    asserts++; if ({res83, mac_a83, mac_b83} !== 48'h0) begin failures++; $display("FAIL rst_data: got %h want 0", {res83, mac_a83, mac_b83}); end
    reset_n83 = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    jl[0] = 4'd1; jl[1] = 4'd1;
    pa[0] = 16'h3C00; pb[0] = 16'h4000;
    ans_tab[0] = 16'h4000; ans_tab[1] = 16'h4000;
    done_base = n_done;
    run(2'b11, 400);
    asserts++; if (gorder[0] !== 0) begin failures++; $display("FAIL rr_first: got %0d want 0", gorder[0]); end
    asserts++; if (gorder[1] !== 1) begin failures++; $display("FAIL rr_second: got %0d want 1", gorder[1]); end
    asserts++; if (n_both !== 0) begin failures++; $display("FAIL rr_both_ready: got %0d cycles want 0", n_both); end
    asserts++; if (rres[1] !== 16'h4000) begin failures++; $display("FAIL rr_res1: got %h want 4000", rres[1]); end
  endtask

  task automatic test_single_job();
    int s0, c0, g0, b0;
    s0 = n_start; c0 = n_clr; g0 = n_g[0]; b0 = n_clrbad;
    jl[0] = 4'd3; jl[1] = 4'd0;
    for (int i = 0; i < 4; i++) begin pa[i] = 16'h3C00; pb[i] = 16'h4000; end
    ans_tab[0] = 16'h4000; ans_tab[1] = 16'h4400; ans_tab[2] = 16'h4600; ans_tab[3] = 16'hFFFF;
    done_base = n_done;
    run(2'b01, 400);
    asserts++; if (n_g[0] - g0 !== 1) begin failures++; $display("FAIL sj_grants: got %0d want 1", n_g[0] - g0); end
    asserts++; if (n_clr - c0 !== 1) begin failures++; $display("FAIL sj_clr: got %0d want 1", n_clr - c0); end
    asserts++; if (n_clrbad - b0 !== 0) begin failures++; $display("FAIL sj_clr_nogrant: got %0d want 0", n_clrbad - b0); end
    asserts++; if (n_start - s0 !== 3) begin failures++; $display("FAIL sj_starts: got %0d want 3", n_start - s0); end
    asserts++; if (rres[0] !== 16'h4600) begin failures++; $display("FAIL sj_res: got %h want 4600", rres[0]); end
    asserts++; if (busy83 !== 1'b0) begin failures++; $display("FAIL sj_busy: got %b want 0", busy83); end
    asserts++; if (res_valid83 !== 2'b00) begin failures++; $display("FAIL sj_valid_drop: got %b want 00", res_valid83); end
  endtask

  task automatic test_zero_len();
    int s0, c0;
    s0 = n_start; c0 = n_clr;
    jl[0] = 4'd0; jl[1] = 4'd0;
    run(2'b10, 50);
    asserts++; if (rcyc[1] !== 0) begin failures++; $display("FAIL zl_latency: got %0d want 0", rcyc[1]); end
    asserts++; if (gcyc[1] !== 0) begin failures++; $display("FAIL zl_grant_cycle: got %0d want 0", gcyc[1]); end
    asserts++; if (rres[1] !== 16'h0000) begin failures++; $display("FAIL zl_res: got %h want 0000", rres[1]); end
    asserts++; if ((n_start - s0) + (n_clr - c0) !== 0) begin failures++; $display("FAIL zl_mac_pulses: got %0d want 0", (n_start - s0) + (n_clr - c0)); end
  endtask

  task automatic test_zero_skip();
    int s0, exp_starts;
    s0 = n_start;
    jl[0] = 4'd2; jl[1] = 4'd0;
    pa[0] = 16'h0000; pb[0] = 16'h4000;
    pa[1] = 16'h3C00; pb[1] = 16'h3C00;
`ifdef FP16_SCHED_ZERO_SKIP_EN
    exp_starts = 1;
    ans_tab[0] = 16'h3C00; ans_tab[1] = 16'hFFFF;
`else
    exp_starts = 2;
    ans_tab[0] = 16'h0000; ans_tab[1] = 16'h3C00;
`endif
    done_base = n_done;
    run(2'b01, 400);
    asserts++; if (n_start - s0 !== exp_starts) begin failures++; $display("FAIL zs_starts: got %0d want %0d", n_start - s0, exp_starts); end
    asserts++; if (rres[0] !== 16'h3C00) begin failures++; $display("FAIL zs_res: got %h want 3C00", rres[0]); end
    asserts++; if ({mac_a83, mac_b83} !== 32'h3C003C00) begin failures++; $display("FAIL zs_operands: got %h want 3C003C00", {mac_a83, mac_b83}); end
  endtask

  task automatic test_timeout();
    mac_en = 1'b0;
    jl[0] = 4'd1; jl[1] = 4'd0;
    pa[0] = 16'h3C00; pb[0] = 16'h3C00;
    run(2'b01, 300);
    asserts++; if (rres[0] !== 16'h7E00) begin failures++; $display("FAIL to_res: got %h want 7E00", rres[0]); end
    asserts++; if (rcyc[0] !== 66) begin failures++; $display("FAIL to_latency: got %0d want 66", rcyc[0]); end
    asserts++; if (err_timeout83 !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", err_timeout83); end
    mac_en = 1'b1;
    ans_tab[0] = 16'h4200;
    done_base = n_done;
    run(2'b01, 300);
    asserts++; if (rres[0] !== 16'h4200) begin failures++; $display("FAIL to_next_res: got %h want 4200", rres[0]); end
    asserts++; if (err_timeout83 !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b want 1", err_timeout83); end
  endtask

  task automatic test_reset_mid_job();
    int s0;
    mac_en = 1'b0;
    req_len83 = 8'h01;
    req_valid83 = 2'b01;
    tick();
    req_valid83 = 2'b00;
    op_valid83 = 2'b01;
    op_a83 = {16'h0, 16'h3C00};
    op_b83 = {16'h0, 16'h3C00};
    tick();
    tick();
    op_valid83 = 2'b00;
    asserts++; if (mac_start83 !== 1'b1) begin failures++; $display("FAIL rm_in_wait: got start %b want 1", mac_start83); end
    reset_n83 = 1'b0;
    tick();
    reset_n83 = 1'b1;
    force_done = 1'b1;
    asserts++; if ({busy83, mac_start83, mac_clr83, err_timeout83} !== 4'b0000) begin failures++; $display("FAIL rm_flags: got %b want 0000", {busy83, mac_start83, mac_clr83, err_timeout83}); end
    asserts++; if ({req_grant83, op_ready83, res_valid83} !== 6'b0) begin failures++; $display("FAIL rm_handshake: got %b want 000000", {req_grant83, op_ready83, res_valid83}); end
    asserts++; if ({res83, mac_a83, mac_b83} !== 48'h0) begin failures++; $display("FAIL rm_data: got %h want 0", {res83, mac_a83, mac_b83}); end
    tick();
    force_done = 1'b0;
    tick();
    asserts++; if ({busy83, res_valid83, res83} !== 19'h0) begin failures++; $display("FAIL rm_late_done: got %h want 0", {busy83, res_valid83, res83}); end
    mac_en = 1'b1;
    s0 = n_start;
    jl[0] = 4'd1; jl[1] = 4'd0;
    pa[0] = 16'h3C00; pb[0] = 16'h3C00;
    ans_tab[0] = 16'h3C00;
    done_base = n_done;
    run(2'b01, 300);
    asserts++; if (rres[0] !== 16'h3C00) begin failures++; $display("FAIL rm_next_res: got %h want 3C00", rres[0]); end
    asserts++; if (n_start - s0 !== 1) begin failures++; $display("FAIL rm_next_starts: got %0d want 1", n_start - s0); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_job();
    test_zero_len();
    test_zero_skip();
    test_timeout();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
